// File: rtl/pst_brain_core.sv
// Phase-synchrony attention core: per-gamma spike phases, pair coherence scoring, STDP weights,
// score predictor, and theta/delta majority voting with confidence/explore control.
module pst_brain_core #(
  parameter logic [7:0] THRESHOLD    = 8'd200,
  parameter logic [7:0] PHASE_TOL    = 8'd20,
  parameter logic [7:0] ETA_LTP      = 8'd4,
  parameter logic [7:0] ETA_LTD      = 8'd2,
  parameter logic [2:0] W_SHIFT      = 3'd3,
  parameter logic [7:0] DECAY_PERIOD = 8'd2,
  parameter logic [7:0] ERR_WIN      = 8'd3,
  parameter logic [7:0] ERR_THR      = 8'd5,
  parameter logic [7:0] SLOT_A_INIT  = 8'd0,
  parameter logic [7:0] SLOT_B_INIT  = 8'd213
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cur0,
  input  logic [7:0] cur1,
  input  logic [7:0] cur2,
  input  logic [7:0] cur3,
  output logic [7:0] phase0,
  output logic [7:0] phase1,
  output logic [7:0] phase2,
  output logic [7:0] phase3,
  output logic [2:0] winner,
  output logic [7:0] winner_score,
  output logic [7:0] winner_rel,
  output logic [7:0] w_ab,
  output logic [7:0] w_ac,
  output logic [7:0] w_ad,
  output logic [7:0] w_bc,
  output logic [7:0] w_bd,
  output logic [7:0] w_cd,
  output logic [7:0] seq_slot_A,
  output logic [7:0] seq_slot_B,
  output logic       seq_force_valid,
  output logic [7:0] seq_force_pred,
  output logic [7:0] pred_out,
  output logic [7:0] pred_err,
  output logic       reward_out,
  output logic [2:0] gamma_cnt,
  output logic [2:0] theta_cnt,
  output logic       theta_tick,
  output logic       episode_last,
  output logic [2:0] ep_winner,
  output logic [3:0] ep_strength,
  output logic       ep_valid,
  output logic       exploit_mode,
  output logic       explore_mode,
  output logic [1:0] confidence_level,
  output logic       err_explore,
  output logic       delta_tick,
  output logic [2:0] topic_winner,
  output logic [2:0] topic_strength,
  output logic       topic_valid
);

  localparam logic [7:0] PERIOD = (DECAY_PERIOD == 8'd0) ? 8'd1 : DECAY_PERIOD;

  logic [7:0]  r_cnt;
  logic [15:0] r_acc    [4];
  logic [3:0]  r_spiked;
  logic [7:0]  r_ph_cur [4];
  logic [7:0]  r_phase  [4];
  logic [7:0]  r_w      [6];
  logic [2:0]  r_winner;
  logic [7:0]  r_win_score, r_win_rel, r_slot_a, r_slot_b, r_pred, r_pred_err;
  logic        r_reward, r_err_explore;
  logic [1:0]  r_rew_run, r_force_left, r_conf;
  logic [7:0]  r_err_run, r_dcnt;
  logic [2:0]  r_gamma_cnt, r_theta_cnt;
  logic [3:0]  r_win_cnt [6];
  logic [2:0]  r_ep_cnt  [6];
  logic        r_theta_tick, r_delta_tick, r_ep_valid, r_topic_valid;
  logic [2:0]  r_ep_winner, r_topic_winner, r_topic_strength;
  logic [3:0]  r_ep_strength;

  logic [7:0]  w_cur [4];
  logic [15:0] w_acc_sum [4];
  logic [3:0]  w_spiked_eff, w_fire;
  logic [7:0]  w_ph_fin [4];
  logic        w_gamma_end, w_explore;

  assign w_cur[0]    = cur0;
  assign w_cur[1]    = cur1;
  assign w_cur[2]    = cur2;
  assign w_cur[3]    = cur3;
  assign w_gamma_end = (r_cnt == 8'd255);
  assign w_explore   = (r_conf <= 2'd1) | r_err_explore;

  // Accumulators restart at clock index 0; the phase includes a spike on the final clock.
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      w_spiked_eff[c] = (r_cnt != 8'd0) && r_spiked[c];
      w_acc_sum[c]    = ((r_cnt == 8'd0) ? 16'd0 : r_acc[c]) + {8'd0, w_cur[c]};
      w_fire[c]       = !w_spiked_eff[c] && (w_acc_sum[c] >= {8'd0, THRESHOLD});
      if (w_spiked_eff[c])  w_ph_fin[c] = r_ph_cur[c];
      else if (w_fire[c])   w_ph_fin[c] = r_cnt;
      else                  w_ph_fin[c] = 8'd255;
    end
  end

  function automatic logic [1:0] pair_a(input int p);
    case (p)
      0, 1, 2: pair_a = 2'd0;
      3, 4:    pair_a = 2'd1;
      default: pair_a = 2'd2;
    endcase
  endfunction

  function automatic logic [1:0] pair_b(input int p);
    case (p)
      0:       pair_b = 2'd1;
      1, 3:    pair_b = 2'd2;
      default: pair_b = 2'd3;
    endcase
  endfunction

  logic [7:0] w_rel [6];
  logic [7:0] w_score [6];
  logic [5:0] w_coh;
  logic [7:0] v_a, v_b, v_diff;
  logic [2:0] v_bias;
  logic [9:0] v_sum;
  logic       v_valid;

  always_comb begin
    v_a = '0; v_b = '0; v_diff = '0; v_bias = '0; v_sum = '0; v_valid = 1'b0;
    w_coh = '0;
    for (int p = 0; p < 6; p++) begin
      v_a      = w_ph_fin[pair_a(p)];
      v_b      = w_ph_fin[pair_b(p)];
      v_diff   = (v_a > v_b) ? (v_a - v_b) : (v_b - v_a);
      v_valid  = (v_a != 8'd255) && (v_b != 8'd255);
      w_rel[p] = v_valid ? (8'd255 - v_diff) : 8'd0;
      w_coh[p] = v_valid && (v_diff <= PHASE_TOL);
      v_bias   = ((!w_explore && r_ep_valid && r_ep_winner == 3'(p)) ? 3'd4 : 3'd0) +
                 ((!w_explore && r_topic_valid && r_topic_winner == 3'(p)) ? 3'd2 : 3'd0);
      v_sum    = 10'(w_rel[p] >> 1) + 10'(r_w[p] >> W_SHIFT) + 10'(v_bias);
      w_score[p] = (v_sum > 10'd255) ? 8'd255 : v_sum[7:0];
    end
  end

  logic [2:0] w_winner;
  logic [7:0] w_best, w_best_rel;

  always_comb begin
    w_winner   = 3'd0;
    w_best     = w_score[0];
    w_best_rel = w_rel[0];
    for (int p = 1; p < 6; p++) begin
      if (w_score[p] > w_best) begin
        w_winner   = 3'(p);
        w_best     = w_score[p];
        w_best_rel = w_rel[p];
      end
    end
  end

  logic [7:0] w_pred, w_err, w_err_run;
  logic       w_reward, w_hi_err, w_decay_now;
  logic [1:0] w_rew_run;

  always_comb begin
    if (r_winner == 3'd0)      w_pred = r_slot_a;
    else if (r_winner == 3'd5) w_pred = r_slot_b;
    else                       w_pred = r_win_score;
    w_err       = (w_best > w_pred) ? (w_best - w_pred) : (w_pred - w_best);
    w_reward    = (w_err < ERR_THR);
    w_hi_err    = (w_err > ERR_THR);
    w_rew_run   = !w_reward ? 2'd0 : ((r_rew_run == 2'd2) ? 2'd2 : r_rew_run + 2'd1);
    w_err_run   = !w_hi_err ? 8'd0 : ((r_err_run == 8'd255) ? 8'd255 : r_err_run + 8'd1);
    w_decay_now = (r_dcnt >= PERIOD - 8'd1);
  end

  logic [7:0] w_w_next [6];
  logic [8:0] v_inc;

  always_comb begin
    v_inc = '0;
    for (int p = 0; p < 6; p++) begin
      w_w_next[p] = r_w[p];
      v_inc       = {1'b0, r_w[p]} + {1'b0, ETA_LTP};
      if (w_winner == 3'(p)) begin
        if (w_coh[p]) w_w_next[p] = (v_inc > 9'd240) ? 8'd240 : v_inc[7:0];
      end else if (w_decay_now) begin
        w_w_next[p] = (r_w[p] > ETA_LTD) ? (r_w[p] - ETA_LTD) : 8'd0;
      end
    end
  end

  // Theta vote over winners (including this gamma) and delta vote over episode winners.
  logic [3:0] w_win_cnt_new [6];
  logic [2:0] w_ep_cnt_new  [6];
  logic [2:0] w_ep_win, w_topic_win, w_topic_str;
  logic [3:0] w_ep_str;
  logic [1:0] w_conf_new;

  always_comb begin
    for (int p = 0; p < 6; p++)
      w_win_cnt_new[p] = r_win_cnt[p] + ((w_winner == 3'(p)) ? 4'd1 : 4'd0);
    w_ep_win = 3'd0;
    w_ep_str = w_win_cnt_new[0];
    for (int p = 1; p < 6; p++)
      if (w_win_cnt_new[p] > w_ep_str) begin
        w_ep_win = 3'(p);
        w_ep_str = w_win_cnt_new[p];
      end
    for (int p = 0; p < 6; p++)
      w_ep_cnt_new[p] = r_ep_cnt[p] + ((w_ep_win == 3'(p)) ? 3'd1 : 3'd0);
    w_topic_win = 3'd0;
    w_topic_str = w_ep_cnt_new[0];
    for (int p = 1; p < 6; p++)
      if (w_ep_cnt_new[p] > w_topic_str) begin
        w_topic_win = 3'(p);
        w_topic_str = w_ep_cnt_new[p];
      end
    w_conf_new = r_conf;
    if (w_ep_str >= 4'd7)      w_conf_new = (r_conf == 2'd3) ? 2'd3 : r_conf + 2'd1;
    else if (w_ep_str <= 4'd5) w_conf_new = (r_conf == 2'd0) ? 2'd0 : r_conf - 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0; r_spiked <= '0;
      for (int c = 0; c < 4; c++) begin
        r_acc[c] <= '0; r_ph_cur[c] <= '0; r_phase[c] <= 8'd255;
      end
      for (int p = 0; p < 6; p++) begin
        r_w[p] <= 8'd128; r_win_cnt[p] <= '0; r_ep_cnt[p] <= '0;
      end
      r_winner <= '0; r_win_score <= '0; r_win_rel <= '0;
      r_slot_a <= SLOT_A_INIT; r_slot_b <= SLOT_B_INIT;
      r_pred <= '0; r_pred_err <= '0; r_reward <= 1'b0;
      r_rew_run <= '0; r_force_left <= '0; r_err_run <= '0; r_err_explore <= 1'b0;
      r_dcnt <= '0; r_gamma_cnt <= '0; r_theta_cnt <= '0; r_conf <= 2'd2;
      r_theta_tick <= 1'b0; r_delta_tick <= 1'b0; r_ep_valid <= 1'b0; r_topic_valid <= 1'b0;
      r_ep_winner <= '0; r_ep_strength <= '0; r_topic_winner <= '0; r_topic_strength <= '0;
    end else begin
      r_cnt        <= r_cnt + 8'd1;
      r_theta_tick <= 1'b0;
      r_delta_tick <= 1'b0;
      for (int c = 0; c < 4; c++) begin
        r_acc[c]    <= w_acc_sum[c];
        r_spiked[c] <= w_spiked_eff[c] | w_fire[c];
        if (w_fire[c]) r_ph_cur[c] <= r_cnt;
      end
      if (w_gamma_end) begin
        for (int c = 0; c < 4; c++) r_phase[c] <= w_ph_fin[c];
        for (int p = 0; p < 6; p++) r_w[p] <= w_w_next[p];
        r_winner    <= w_winner;
        r_win_score <= w_best;
        r_win_rel   <= w_best_rel;
        r_slot_a    <= w_score[0];
        r_slot_b    <= w_score[5];
        r_pred      <= w_pred;
        r_pred_err  <= w_err;
        r_reward    <= w_reward;
        r_rew_run   <= w_rew_run;
        if (w_rew_run == 2'd2)         r_force_left <= 2'd2;
        else if (r_force_left != 2'd0) r_force_left <= r_force_left - 2'd1;
        r_err_run <= w_err_run;
        if (w_reward)                    r_err_explore <= 1'b0;
        else if (w_err_run >= ERR_WIN)   r_err_explore <= 1'b1;
        r_dcnt      <= w_decay_now ? 8'd0 : r_dcnt + 8'd1;
        r_gamma_cnt <= r_gamma_cnt + 3'd1;
        if (r_gamma_cnt == 3'd7) begin
          for (int p = 0; p < 6; p++) r_win_cnt[p] <= '0;
          r_ep_winner   <= w_ep_win;
          r_ep_strength <= w_ep_str;
          r_ep_valid    <= 1'b1;
          r_conf        <= w_conf_new;
          r_theta_tick  <= 1'b1;
          if (r_theta_cnt == 3'd4) begin
            r_theta_cnt <= '0;
            for (int p = 0; p < 6; p++) r_ep_cnt[p] <= '0;
            r_topic_winner   <= w_topic_win;
            r_topic_strength <= w_topic_str;
            r_topic_valid    <= 1'b1;
            r_delta_tick     <= 1'b1;
          end else begin
            r_theta_cnt <= r_theta_cnt + 3'd1;
            for (int p = 0; p < 6; p++) r_ep_cnt[p] <= w_ep_cnt_new[p];
          end
        end else begin
          for (int p = 0; p < 6; p++) r_win_cnt[p] <= w_win_cnt_new[p];
        end
      end
    end
  end

  assign phase0 = r_phase[0];
  assign phase1 = r_phase[1];
  assign phase2 = r_phase[2];
  assign phase3 = r_phase[3];
  assign winner = r_winner;
  assign winner_score = r_win_score;
  assign winner_rel   = r_win_rel;
  assign w_ab = r_w[0];
  assign w_ac = r_w[1];
  assign w_ad = r_w[2];
  assign w_bc = r_w[3];
  assign w_bd = r_w[4];
  assign w_cd = r_w[5];
  assign seq_slot_A      = r_slot_a;
  assign seq_slot_B      = r_slot_b;
  assign seq_force_valid = (r_force_left != 2'd0);
  assign seq_force_pred  = seq_force_valid ? r_pred : 8'd0;
  assign pred_out        = r_pred;
  assign pred_err        = r_pred_err;
  assign reward_out      = r_reward;
  assign gamma_cnt       = r_gamma_cnt;
  assign theta_cnt       = r_theta_cnt;
  assign theta_tick      = r_theta_tick;
  assign episode_last    = (r_gamma_cnt == 3'd7);
  assign ep_winner       = r_ep_winner;
  assign ep_strength     = r_ep_strength;
  assign ep_valid        = r_ep_valid;
  assign exploit_mode    = (r_conf == 2'd3);
  assign explore_mode    = w_explore;
  assign confidence_level = r_conf;
  assign err_explore     = r_err_explore;
  assign delta_tick      = r_delta_tick;
  assign topic_winner    = r_topic_winner;
  assign topic_strength  = r_topic_strength;
  assign topic_valid     = r_topic_valid;

endmodule

// File: tb/tb_pst_brain_core.sv
// Bench for pst_brain_core: gamma-level behavioural model feeding an expected queue,
// per-cycle output compare, plus hand-computed literal pins.
module tb_pst_brain_core;

  localparam int W = 170;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] cur0 = '0, cur1 = '0, cur2 = '0, cur3 = '0;
  logic [7:0] phase0, phase1, phase2, phase3;
  logic [2:0] winner;
  logic [7:0] winner_score, winner_rel;
  logic [7:0] w_ab, w_ac, w_ad, w_bc, w_bd, w_cd;
  logic [7:0] seq_slot_A, seq_slot_B, seq_force_pred, pred_out, pred_err;
  logic       seq_force_valid, reward_out, theta_tick, episode_last, ep_valid;
  logic [2:0] gamma_cnt, theta_cnt, ep_winner, topic_winner, topic_strength;
  logic [3:0] ep_strength;
  logic       exploit_mode, explore_mode, err_explore, delta_tick, topic_valid;
  logic [1:0] confidence_level;

  pst_brain_core dut (
    .clk(clk), .rst(rst), .cur0(cur0), .cur1(cur1), .cur2(cur2), .cur3(cur3),
    .phase0(phase0), .phase1(phase1), .phase2(phase2), .phase3(phase3),
    .winner(winner), .winner_score(winner_score), .winner_rel(winner_rel),
    .w_ab(w_ab), .w_ac(w_ac), .w_ad(w_ad), .w_bc(w_bc), .w_bd(w_bd), .w_cd(w_cd),
    .seq_slot_A(seq_slot_A), .seq_slot_B(seq_slot_B),
    .seq_force_valid(seq_force_valid), .seq_force_pred(seq_force_pred),
    .pred_out(pred_out), .pred_err(pred_err), .reward_out(reward_out),
    .gamma_cnt(gamma_cnt), .theta_cnt(theta_cnt), .theta_tick(theta_tick),
    .episode_last(episode_last), .ep_winner(ep_winner), .ep_strength(ep_strength),
    .ep_valid(ep_valid), .exploit_mode(exploit_mode), .explore_mode(explore_mode),
    .confidence_level(confidence_level), .err_explore(err_explore),
    .delta_tick(delta_tick), .topic_winner(topic_winner),
    .topic_strength(topic_strength), .topic_valid(topic_valid)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  bit  m_pushed = 1'b0;

  logic [W-1:0] dut_vec;
  assign dut_vec = {phase0, phase1, phase2, phase3, winner, winner_score, winner_rel,
                    w_ab, w_ac, w_ad, w_bc, w_bd, w_cd, seq_slot_A, seq_slot_B,
                    seq_force_valid, seq_force_pred, pred_out, pred_err, reward_out,
                    gamma_cnt, theta_cnt, theta_tick, episode_last, ep_winner, ep_strength,
                    ep_valid, exploit_mode, explore_mode, confidence_level, err_explore,
                    delta_tick, topic_winner, topic_strength, topic_valid};

  // ---------------- behavioural model ----------------
  int hist [256][4];
  int m_clk, m_gammas, m_thetas;
  int m_ph [4];
  int m_w  [6];
  int m_winner, m_score, m_rel, m_slot_a, m_slot_b, m_pred, m_err, m_err_streak;
  bit m_reward, m_force, m_errx, m_r1, m_r2;
  int m_conf, m_ep_w, m_ep_str, m_topic_w, m_topic_str;
  bit m_ep_valid, m_topic_valid, m_theta_tick, m_delta_tick;
  int theta_wins[$];
  int ep_hist[$];
  int pa [6] = '{0, 0, 0, 1, 1, 2};
  int pb [6] = '{1, 2, 3, 2, 3, 3};

  task automatic model_reset();
    m_clk = 0; m_gammas = 0; m_thetas = 0;
    for (int c = 0; c < 4; c++) m_ph[c] = 255;
    for (int p = 0; p < 6; p++) m_w[p] = 128;
    m_winner = 0; m_score = 0; m_rel = 0; m_slot_a = 0; m_slot_b = 213;
    m_pred = 0; m_err = 0; m_err_streak = 0;
    m_reward = 0; m_force = 0; m_errx = 0; m_r1 = 0; m_r2 = 0;
    m_conf = 2; m_ep_w = 0; m_ep_str = 0; m_topic_w = 0; m_topic_str = 0;
    m_ep_valid = 0; m_topic_valid = 0; m_theta_tick = 0; m_delta_tick = 0;
    theta_wins.delete();
    ep_hist.delete();
  endtask

  // Majority vote over a list of pair ids: highest count, lowest pair id on ties.
  task automatic vote(input int lst[$], output int win, output int cnt);
    int counts [6];
    for (int p = 0; p < 6; p++) counts[p] = 0;
    foreach (lst[i]) counts[lst[i]]++;
    win = 0;
    for (int p = 1; p < 6; p++) if (counts[p] > counts[win]) win = p;
    cnt = counts[win];
  endtask

  task automatic model_gamma_end();
    int sc [6];
    int rl [6];
    bit coh [6];
    int sum, d, win, pred;
    bit expl;
    for (int c = 0; c < 4; c++) begin
      sum = 0;
      m_ph[c] = 255;
      for (int k = 0; k < 256; k++) begin
        sum += hist[k][c];
        if (sum >= 200) begin m_ph[c] = k; break; end
      end
    end
    expl = (m_conf <= 1) || m_errx;
    for (int p = 0; p < 6; p++) begin
      d = m_ph[pa[p]] - m_ph[pb[p]];
      if (d < 0) d = -d;
      if (m_ph[pa[p]] == 255 || m_ph[pb[p]] == 255) begin
        rl[p] = 0; coh[p] = 0;
      end else begin
        rl[p] = 255 - d; coh[p] = (d <= 20);
      end
      sc[p] = rl[p] / 2 + m_w[p] / 8;
      if (!expl && m_ep_valid && m_ep_w == p) sc[p] += 4;
      if (!expl && m_topic_valid && m_topic_w == p) sc[p] += 2;
      if (sc[p] > 255) sc[p] = 255;
    end
    win = 0;
    for (int p = 1; p < 6; p++) if (sc[p] > sc[win]) win = p;
    pred = (m_winner == 0) ? m_slot_a : ((m_winner == 5) ? m_slot_b : m_score);
    m_err = sc[win] - pred;
    if (m_err < 0) m_err = -m_err;
    m_reward = (m_err < 5);
    m_force = (m_reward && m_r1) || (m_r1 && m_r2);
    m_r2 = m_r1; m_r1 = m_reward;
    m_err_streak = (m_err > 5) ? m_err_streak + 1 : 0;
    if (m_reward) m_errx = 0;
    else if (m_err_streak >= 3) m_errx = 1;
    m_gammas++;
    for (int p = 0; p < 6; p++) begin
      if (p == win) begin
        if (coh[p]) m_w[p] = (m_w[p] + 4 > 240) ? 240 : m_w[p] + 4;
      end else if (m_gammas % 2 == 0) begin
        m_w[p] = (m_w[p] > 2) ? m_w[p] - 2 : 0;
      end
    end
    m_slot_a = sc[0]; m_slot_b = sc[5];
    m_pred = pred; m_winner = win; m_score = sc[win]; m_rel = rl[win];
    theta_wins.push_back(win);
    if (theta_wins.size() == 8) begin
      vote(theta_wins, m_ep_w, m_ep_str);
      m_ep_valid = 1; m_theta_tick = 1;
      if (m_ep_str >= 7) m_conf = (m_conf == 3) ? 3 : m_conf + 1;
      else if (m_ep_str <= 5) m_conf = (m_conf == 0) ? 0 : m_conf - 1;
      theta_wins.delete();
      m_thetas++;
      ep_hist.push_back(m_ep_w);
      if (ep_hist.size() == 5) begin
        vote(ep_hist, m_topic_w, m_topic_str);
        m_topic_valid = 1; m_delta_tick = 1;
        ep_hist.delete();
      end
    end
  endtask

  function automatic logic [W-1:0] model_vec();
    return {8'(m_ph[0]), 8'(m_ph[1]), 8'(m_ph[2]), 8'(m_ph[3]), 3'(m_winner), 8'(m_score),
            8'(m_rel), 8'(m_w[0]), 8'(m_w[1]), 8'(m_w[2]), 8'(m_w[3]), 8'(m_w[4]), 8'(m_w[5]),
            8'(m_slot_a), 8'(m_slot_b), m_force, 8'(m_force ? m_pred : 0), 8'(m_pred),
            8'(m_err), m_reward, 3'(m_gammas % 8), 3'(m_thetas % 5), m_theta_tick,
            1'(m_gammas % 8 == 7), 3'(m_ep_w), 4'(m_ep_str), m_ep_valid, 1'(m_conf == 3),
            1'((m_conf <= 1) || m_errx), 2'(m_conf), m_errx, m_delta_tick, 3'(m_topic_w),
            3'(m_topic_str), m_topic_valid};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      model_reset();
    end else begin
      m_theta_tick = 0;
      m_delta_tick = 0;
      hist[m_clk][0] = cur0; hist[m_clk][1] = cur1;
      hist[m_clk][2] = cur2; hist[m_clk][3] = cur3;
      if (m_clk == 255) model_gamma_end();
      m_clk = (m_clk + 1) % 256;
    end
    exp_q.push_back(model_vec());
    m_pushed = 1'b1;
  end

  // ---------------- compare process ----------------
  logic [W-1:0] exp_v;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      n_checks++;
      if (dut_vec !== exp_v) begin
        n_fail++;
        $display("FAIL outs t=%0t got=%h exp=%h", $time, dut_vec, exp_v);
      end
    end else if (m_pushed) begin
      n_checks++;
      n_fail++;
      $display("FAIL exp_q_empty t=%0t got=empty exp=entry", $time);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_lit(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic run_clocks(input int n, input int c0, input int c1, input int c2,
                            input int c3, input bit jitter);
    for (int k = 0; k < n; k++) begin
      cur0 = jitter ? 8'($urandom_range(0, c0)) : 8'(c0);
      cur1 = jitter ? 8'($urandom_range(0, c1)) : 8'(c1);
      cur2 = jitter ? 8'($urandom_range(0, c2)) : 8'(c2);
      cur3 = jitter ? 8'($urandom_range(0, c3)) : 8'(c3);
      @(negedge clk);
    end
  endtask

  task automatic run_gammas(input int g, input int c0, input int c1, input int c2, input int c3);
    for (int i = 0; i < g; i++) run_clocks(256, c0, c1, c2, c3, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check_lit({tag, "_w_ab"}, w_ab, 128);
    check_lit({tag, "_w_cd"}, w_cd, 128);
    check_lit({tag, "_slot_b"}, seq_slot_B, 213);
    check_lit({tag, "_conf"}, confidence_level, 2);
    check_lit({tag, "_phase0"}, phase0, 255);
    check_lit({tag, "_winner"}, winner, 0);
    check_lit({tag, "_w_x"}, $isunknown({w_ab, w_ac, w_ad, w_bc, w_bd, w_cd}) ? 1 : 0, 0);
  endtask

  // ---------------- main sequence ----------------
  int rc [4];
  initial begin
    repeat (3) @(negedge clk);
    check_reset_values("rst0");
    rst = 1'b0;

    // First gamma: phases 0,9,1,1 -> AC/AD/CD tie at 143, AC wins (lowest index).
    run_gammas(1, 200, 20, 195, 180);
    check_lit("g1_phase1", phase1, 9);
    check_lit("g1_phase2", phase2, 1);
    check_lit("g1_winner", winner, 1);
    check_lit("g1_score", winner_score, 143);
    check_lit("g1_rel", winner_rel, 254);
    check_lit("g1_w_ac", w_ac, 132);
    check_lit("g1_pred_err", pred_err, 143);
    check_lit("g1_slot_a", seq_slot_A, 139);
    check_lit("g1_slot_b", seq_slot_B, 143);
    run_gammas(19, 200, 20, 195, 180);

    // Training on A/B: AB wins every gamma and climbs to the homeostatic cap.
    run_gammas(100, 200, 180, 5, 8);
    check_lit("train_w_ab", w_ab, 240);
    check_lit("train_winner", winner, 0);
    check_lit("train_ep_winner", ep_winner, 0);
    check_lit("train_ep_strength", ep_strength, 8);
    check_lit("train_conf", confidence_level, 3);
    check_lit("train_exploit", exploit_mode, 1);
    check_lit("train_topic_str", topic_strength, 5);

    run_gammas(20, 200, 20, 195, 180);
    for (int i = 0; i < 16; i++) begin
      run_gammas(1, 200, 180, 5, 8);
      run_gammas(1, 5, 8, 200, 180);
    end
    run_gammas(48, 200, 180, 5, 8);

    for (int g = 0; g < 30; g++) begin
      for (int c = 0; c < 4; c++)
        rc[c] = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 60) : $urandom_range(100, 255);
      run_clocks(256, rc[0], rc[1], rc[2], rc[3], 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a gamma.
    run_clocks(100, 200, 180, 5, 8, 1'b0);
    #1 rst = 1'b1;
    @(negedge clk);
    check_reset_values("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    run_gammas(4, 200, 20, 195, 180);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
